// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, clear FSM states and address helper for regfile_sb
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
  function automatic logic addr_is_zero(input logic [31:0] a);
    return a == 32'd0;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; issue beats write-back, clear sweep overrides both
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic             wipe_en,
  input  logic [AW-1:0]    wipe_addr,
  output logic [NREGS-1:0] busy
);
  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else if (wipe_en) busy[wipe_addr] <= 1'b0;
    else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with busy scoreboard and sequential clear; r0 reads as zero
// Define REGFILE_BYPASS_EN to forward the current write-back to matching read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_val,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_val,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              clr_req,
  output logic              clr_busy
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  clr_state_t state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic run, last, we, se;
  assign run = state == CLR_RUN;
  assign last = idx == AW'(NREGS - 1);
  assign we = wr_en && !run && !addr_is_zero(32'(wr_addr));
  assign se = iss_en && !run && !addr_is_zero(32'(iss_addr));
  assign clr_busy = run;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLR_IDLE;
      idx <= AW'(1);
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  always_comb begin
    state_n = run ? (last ? CLR_IDLE : CLR_RUN) : (clr_req ? CLR_RUN : CLR_IDLE);
    idx_n = (run && !last) ? idx + AW'(1) : AW'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (run) regs[idx] <= '0;
    else if (we) regs[wr_addr] <= wr_val;
  end
  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_en    (se),
    .set_addr  (iss_addr),
    .clr_en    (we),
    .clr_addr  (wr_addr),
    .wipe_en   (run),
    .wipe_addr (idx),
    .busy      (busy)
  );
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic byp, z;
    assign a = rd_addr[k*AW +: AW];
    assign z = addr_is_zero(32'(a));
`ifdef REGFILE_BYPASS_EN
    assign byp = we && a == wr_addr;
`else
    assign byp = 1'b0;
`endif
    assign rd_val[k*XLEN +: XLEN] = z ? '0 : byp ? wr_val : regs[a];
    assign rd_busy[k] = !z && !byp && busy[a];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed stimulus against a behavioural register file model plus literal checks
module tb_regfile_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_val;
  logic [NRD-1:0] rd_busy;
  logic wr_en = 1'b0, iss_en = 1'b0, clr_req = 1'b0, clr_busy;
  logic [AW-1:0] wr_addr = '0, iss_addr = '0;
  logic [XLEN-1:0] wr_val = '0;
  int n_vec = 0, n_err = 0, cnt;
  bit chk = 1'b0;
  logic [XLEN-1:0] m_reg [NREGS];
  bit m_busy [NREGS];
  int m_left = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val), .iss_en(iss_en), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clock = ~clock;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural state updated per edge; clear walks upward from r1 while m_left > 0
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
      m_left = 0;
    end else if (m_left > 0) begin
      m_reg[NREGS - m_left] = '0;
      m_busy[NREGS - m_left] = 1'b0;
      m_left--;
    end else begin
      if (wr_en && wr_addr != 0) begin m_reg[wr_addr] = wr_val; m_busy[wr_addr] = 1'b0; end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (clr_req) m_left = NREGS - 1;
    end
  end

  function automatic logic fwd(int k);
    logic [AW-1:0] a;
    a = rd_addr[k*AW +: AW];
    return BYP && wr_en && m_left == 0 && wr_addr != 0 && a == wr_addr;
  endfunction

  always @(negedge clock) begin
    if (chk) begin
      for (int k = 0; k < NRD; k++) begin
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        check("model_rd_val", rd_val[k*XLEN +: XLEN], a == 0 ? 32'd0 : fwd(k) ? wr_val : m_reg[a]);
        check("model_rd_busy", 32'(rd_busy[k]), 32'(a != 0 && !fwd(k) && m_busy[a]));
      end
      check("model_clr_busy", 32'(clr_busy), 32'(m_left > 0));
    end
  end

  task automatic cyc(); @(posedge clock); #1; endtask
  task automatic probe(); @(negedge clock); endtask
  task automatic ra(logic [AW-1:0] a0, logic [AW-1:0] a1); rd_addr = {a1, a0}; endtask
  task automatic lit(string nm, int k, logic [31:0] v, logic b);
    check({nm, "_val"}, rd_val[k*XLEN +: XLEN], v);
    check({nm, "_busy"}, 32'(rd_busy[k]), 32'(b));
  endtask
  function automatic logic [31:0] fill(int i); return 32'h1000_0000 + 32'(i); endfunction
  task automatic fill_all();
    for (int i = 1; i < NREGS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_val = fill(i);
      iss_en = (i % 2 == 0); iss_addr = AW'(i);
      cyc();
    end
    wr_en = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    ra(5, 0);
    cyc(); chk = 1'b1; cyc();
    reset = 1'b0;
    probe();
    lit("reset_p0", 0, 0, 0); lit("reset_p1", 1, 0, 0);
    check("reset_clr_busy", 32'(clr_busy), 0);
    cyc();
    ra(7, 0); iss_en = 1'b1; iss_addr = 7;
    cyc();
    iss_en = 1'b0; wr_en = 1'b1; wr_addr = 7; wr_val = 32'hDEAD_BEEF;
    probe();
    lit("issue7", 0, BYP ? 32'hDEAD_BEEF : 32'd0, !BYP);
    cyc();
    wr_en = 1'b0;
    probe();
    lit("wb7", 0, 32'hDEAD_BEEF, 0);
    cyc();
    ra(7, 9); wr_en = 1'b1; wr_addr = 9; wr_val = 32'h1234; iss_en = 1'b1; iss_addr = 9;
    cyc();
    wr_en = 1'b0; iss_en = 1'b0;
    probe();
    lit("same9", 1, 32'h1234, 1);
    cyc();
    ra(0, 9); wr_en = 1'b1; wr_addr = 0; wr_val = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 0;
    probe();
    lit("zero_now", 0, 0, 0);
    cyc();
    wr_en = 1'b0; iss_en = 1'b0;
    repeat (3) cyc();
    probe();
    lit("zero_later", 0, 0, 0);
    cyc();
    wr_en = 1'b1; wr_addr = 3; wr_val = 32'h11;
    cyc();
    ra(3, 0); wr_val = 32'hA5;
    probe();
    lit("byp3", 0, BYP ? 32'hA5 : 32'h11, 0);
    cyc();
    wr_en = 1'b0;
    probe();
    lit("after3", 0, 32'hA5, 0);
    cyc();
    fill_all();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    cnt = 0;
    for (int c = 1; c <= NREGS + 2; c++) begin
      ra(AW'(c), AW'(c - 1));
      if (c == 5) begin wr_en = 1'b1; wr_addr = 20; wr_val = 32'h77; iss_en = 1'b1; iss_addr = 20; end
      probe();
      if (clr_busy) cnt++;
      if (c < NREGS) begin
        check("clr_pending", rd_val[XLEN-1:0], fill(c));
        check("clr_done", rd_val[2*XLEN-1:XLEN], 0);
      end
      cyc();
      wr_en = 1'b0; iss_en = 1'b0;
    end
    check("clr_cycles", 32'(cnt), NREGS - 1);
    ra(20, 31);
    probe();
    lit("clr_r20", 0, 0, 0); lit("clr_r31", 1, 0, 0);
    cyc();
    fill_all();
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (9) cyc();
    ra(25, 12);
    probe();
    lit("pre_abort", 0, fill(25), 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    probe();
    check("abort_clr_busy", 32'(clr_busy), 0);
    lit("abort_r25", 0, 0, 0); lit("abort_r12", 1, 0, 0);
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with N combinational read ports, one write-back port, a per-register busy scoreboard and a multi-cycle clear sequencer. It is the next-generation architectural register file for the pipelined core. It sits between decode/issue, which reads operands and marks destinations busy, and write-back, which retires results and clears busy bits. Register 0 is hard-wired to zero.

## Interface
- XLEN, 32, data width
- NREGS, 32, register count (power of two, ≥4)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), address width (derived, not overridden)

- clock  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_val  out  NRD*XLEN  packed read data, combinational
- rd_busy  out  NRD  scoreboard busy flag per read port, combinational
- wr_en  in  1  write-back valid
- wr_addr  in  AW  write-back destination
- wr_val  in  XLEN  write-back data
- iss_en  in  1  issue valid; marks iss_addr busy
- iss_addr  in  AW  issued destination
- clr_req  in  1  start clear sequence (single-cycle pulse sufficient)
- clr_busy  out  1  clear sequence in progress

## Operation
- Reads: rd_val[k] = 0 and rd_busy[k] = 0 when rd_addr[k] == 0; otherwise register contents and busy bit.
- Write: on wr_en with wr_addr != 0, the register takes wr_val at the edge and its busy bit is cleared. Writes to address 0 are dropped.
- Issue: on iss_en with iss_addr != 0, the busy bit is set at the edge. Issues to address 0 are dropped.
- Simultaneous wr_en and iss_en to the same address: data is written and busy ends set (the new issue wins).
- Clear FSM has two states, IDLE and CLEAR. In IDLE, clr_req moves the FSM to CLEAR with index = 1. In CLEAR, one register per cycle (index 1..NREGS-1) is zeroed and its busy bit cleared. After index NREGS-1 the FSM returns to IDLE. The sequence takes exactly NREGS-1 cycles in CLEAR.
- In CLEAR, wr_en, iss_en and clr_req are ignored. Reads stay live and return 0 for registers already cleared.
- Reset: all registers = 0, all busy bits = 0, FSM = IDLE, index = 1, clr_busy = 0. Reset mid-clear aborts the sequence immediately.

## Timing
- Read latency 0 (combinational from rd_addr and state).
- Write visible on rd_val in the cycle after the wr_en edge (see Configuration for same-cycle visibility).
- Busy set or clear visible in the cycle after the edge.
- clr_busy rises in the cycle after the clr_req edge and stays high for NREGS-1 cycles.
- No handshake back-pressure: the owner of clr_req must not issue or write while clr_busy = 1. Traffic presented then is lost by design.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en is active (not in CLEAR) and rd_addr[k] == wr_addr != 0, rd_val[k] = wr_val and rd_busy[k] = 0 in the same cycle.
- REGFILE_BYPASS_EN undefined: no forwarding. Reads return the stored value and stored busy bit until the edge.

## Structure
- Package regfile_pkg holds:
  - default XLEN/NREGS constants
  - the clear FSM state enum (CLR_IDLE, CLR_RUN)
  - a helper function for address-zero checks
- Sub-module regfile_scoreboard holds the NREGS busy bits, the set/clear priority and the clear-index reset. The data array, read muxing, bypass and FSM stay in regfile_sb.

## Test plan
- Reset, then read ports 0/1 at addresses 5/0 -> rd_val = 0/0, rd_busy = 0/0, clr_busy = 0.
- iss_en to 7, then wr_en 7 = 0xDEADBEEF next cycle -> rd_busy for 7 = 1 for one cycle, then rd_val = 0xDEADBEEF with busy = 0.
- Same-cycle iss_en and wr_en to 9 with value 0x1234 -> next cycle rd_val = 0x1234, rd_busy = 1.
- Write 0xFFFFFFFF to address 0 and issue to 0 -> rd_val = 0, rd_busy = 0 forever.
- Write 0xA5 to address 3. With the macro defined, read 3 in the write cycle -> 0xA5. With the macro undefined -> old value, then 0xA5 the next cycle.
- Fill all registers, pulse clr_req -> clr_busy = 1 for 31 cycles, register k reads 0 from cycle k+1. A wr_en during CLEAR is dropped. Reset at cycle 10 -> all 0, clr_busy = 0 next cycle.
